// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash operation sequencer: flash opcodes,
// request op encodings, sequencer state encoding and the page-range helper.
package spi_flash_pkg;

    // Flash command opcodes sent to the SPI engine
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_PP    = 8'h02;
    localparam logic [7:0] CMD_SE    = 8'h20;
    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] CMD_RDID  = 8'h9F;

    // Number of ID bytes returned by READ_ID
    localparam logic [15:0] RDID_BYTES = 16'd3;

    // Flash page size; a page program must not cross a page boundary
    localparam logic [16:0] PAGE_BYTES = 17'd256;

    // Request op encodings on i_op
    typedef enum logic [1:0] {
        OP_READ      = 2'b00,
        OP_PROGRAM   = 2'b01,
        OP_ERASE     = 2'b10,
        OP_READ_ID   = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WREN      = 3'd1,
        ST_WREN_WAIT = 3'd2,
        ST_OP        = 3'd3,
        ST_OP_WAIT   = 3'd4,
        ST_POLL      = 3'd5,
        ST_POLL_WAIT = 3'd6,
        ST_DONE      = 3'd7
    } state_e;

    // A page program is rejected when it is empty, longer than a page, or
    // would wrap past the end of the page that holds its start address.
    function automatic logic prog_range_bad(input logic [7:0] addr_lo, input logic [15:0] len);
        logic [16:0] end_off;
        end_off = {9'd0, addr_lo} + {1'b0, len};
        return (len == 16'd0) || (end_off > PAGE_BYTES);
    endfunction

endpackage

// File: rtl/spi_flash_seq.sv
// SPI flash operation sequencer. Turns a single READ / PROGRAM / SECTOR_ERASE /
// READ_ID request into the sequence of engine commands the flash needs
// (write-enable, the operation itself, status polling until WIP clears).
//
// Engine handshake: a command is issued by a one-cycle o_eng_start pulse,
// raised only in a cycle where i_eng_rdy=1; the command fields are valid in
// that cycle and held until the command completes. The engine takes the
// command by dropping i_eng_rdy (within two cycles of the start pulse) and
// signals completion by raising it again. A command counts as complete only
// once rdy has been seen low and then high again, so a stale rdy=1 right
// after the start pulse is never mistaken for completion.
module spi_flash_seq
    import spi_flash_pkg::*;
#(
    parameter logic [15:0] POLL_MAX = 16'd4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic [1:0]  i_op,
    input  logic [23:0] i_addr,
    input  logic [15:0] i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [7:0]  o_sts,
    output logic        o_eng_start,
    output logic [7:0]  o_eng_cmd,
    output logic [23:0] o_eng_addr,
    output logic        o_eng_exi_addr,
    output logic [2:0]  o_eng_dum_num,
    output logic        o_eng_exi_data,
    output logic [15:0] o_eng_data_num,
    output logic        o_eng_wr_en,
    input  logic        i_eng_rdy,
    input  logic [7:0]  i_eng_rdata,
    input  logic        i_eng_rdata_vld,
    output state_e      o_dbg_state
);

    state_e      state_q;
    op_e         op_q;
    logic [23:0] addr_q;
    logic [15:0] len_q;
    logic [15:0] poll_cnt_q;
    logic        seen_busy_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [7:0]  sts_q;
    logic        eng_start_q;
    logic [7:0]  eng_cmd_q;
    logic [23:0] eng_addr_q;
    logic        eng_exi_addr_q;
    logic [2:0]  eng_dum_q;
    logic        eng_exi_data_q;
    logic [15:0] eng_num_q;
    logic        eng_wr_en_q;

    // Command fields for the command the current issue state would send
    logic [7:0]  cmd_d;
    logic [23:0] addr_d;
    logic        exi_addr_d;
    logic [2:0]  dum_d;
    logic        exi_data_d;
    logic [15:0] num_d;
    logic        wr_en_d;

    // Status byte including a read-data beat arriving this very cycle
    logic [7:0]  sts_d;
    logic        wait_done;
    logic        prog_bad;

    assign sts_d     = i_eng_rdata_vld ? i_eng_rdata : sts_q;
    assign wait_done = seen_busy_q & i_eng_rdy;
    assign prog_bad  = prog_range_bad(i_addr[7:0], i_len);

    // Select the command fields that belong to the current issue state
    always_comb begin
        cmd_d      = 8'h00;
        addr_d     = 24'h000000;
        exi_addr_d = 1'b0;
        dum_d      = 3'd0;
        exi_data_d = 1'b0;
        num_d      = 16'd0;
        wr_en_d    = 1'b0;
        case (state_q)
            ST_WREN: begin
                cmd_d = CMD_WREN;
            end
            ST_OP: begin
                case (op_q)
                    OP_READ: begin
                        cmd_d      = CMD_READ;
                        addr_d     = addr_q;
                        exi_addr_d = 1'b1;
                        exi_data_d = 1'b1;
                        num_d      = len_q;
                    end
                    OP_PROGRAM: begin
                        cmd_d      = CMD_PP;
                        addr_d     = addr_q;
                        exi_addr_d = 1'b1;
                        exi_data_d = 1'b1;
                        num_d      = len_q;
                        wr_en_d    = 1'b1;
                    end
                    OP_ERASE: begin
                        cmd_d      = CMD_SE;
                        addr_d     = addr_q;
                        exi_addr_d = 1'b1;
                    end
                    default: begin
                        cmd_d      = CMD_RDID;
                        exi_data_d = 1'b1;
                        num_d      = RDID_BYTES;
                    end
                endcase
            end
            ST_POLL: begin
                cmd_d      = CMD_RDSR;
                exi_data_d = 1'b1;
                num_d      = 16'd1;
            end
            default: begin
            end
        endcase
    end

    // Sequencer FSM with registered handshake, status and engine outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_READ;
            addr_q         <= 24'h000000;
            len_q          <= 16'd0;
            poll_cnt_q     <= 16'd0;
            seen_busy_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            sts_q          <= 8'h00;
            eng_start_q    <= 1'b0;
            eng_cmd_q      <= 8'h00;
            eng_addr_q     <= 24'h000000;
            eng_exi_addr_q <= 1'b0;
            eng_dum_q      <= 3'd0;
            eng_exi_data_q <= 1'b0;
            eng_num_q      <= 16'd0;
            eng_wr_en_q    <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;

            // Any issue state that sees the engine ready launches its command
            if ((state_q == ST_WREN || state_q == ST_OP || state_q == ST_POLL) && i_eng_rdy) begin
                eng_start_q    <= 1'b1;
                eng_cmd_q      <= cmd_d;
                eng_addr_q     <= addr_d;
                eng_exi_addr_q <= exi_addr_d;
                eng_dum_q      <= dum_d;
                eng_exi_data_q <= exi_data_d;
                eng_num_q      <= num_d;
                eng_wr_en_q    <= wr_en_d;
                seen_busy_q    <= 1'b0;
            end else if (!i_eng_rdy) begin
                seen_busy_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_req) begin
                        op_q       <= op_e'(i_op);
                        addr_q     <= i_addr;
                        len_q      <= i_len;
                        poll_cnt_q <= 16'd0;
                        busy_q     <= 1'b1;
                        case (op_e'(i_op))
                            OP_READ: begin
                                if (i_len == 16'd0) begin
                                    state_q <= ST_DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= ST_OP;
                                end
                            end
                            OP_PROGRAM: begin
                                if (prog_bad) begin
                                    state_q <= ST_DONE;
                                    done_q  <= 1'b1;
                                    err_q   <= 1'b1;
                                end else begin
                                    state_q <= ST_WREN;
                                end
                            end
                            OP_ERASE: state_q <= ST_WREN;
                            default:  state_q <= ST_OP;
                        endcase
                    end
                end
                ST_WREN: begin
                    if (i_eng_rdy) state_q <= ST_WREN_WAIT;
                end
                ST_WREN_WAIT: begin
                    if (wait_done) state_q <= ST_OP;
                end
                ST_OP: begin
                    if (i_eng_rdy) state_q <= ST_OP_WAIT;
                end
                ST_OP_WAIT: begin
                    if (wait_done) begin
                        if (op_q == OP_PROGRAM || op_q == OP_ERASE) begin
                            state_q <= ST_POLL;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_POLL: begin
                    if (i_eng_rdy) begin
                        state_q <= ST_POLL_WAIT;
                        if (poll_cnt_q != 16'hFFFF) poll_cnt_q <= poll_cnt_q + 16'd1;
                    end
                end
                ST_POLL_WAIT: begin
                    if (i_eng_rdata_vld) sts_q <= i_eng_rdata;
                    if (wait_done) begin
                        if (!sts_d[0]) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (poll_cnt_q < POLL_MAX) begin
                            state_q <= ST_POLL;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_err          = err_q;
    assign o_sts          = sts_q;
    assign o_eng_start    = eng_start_q;
    assign o_eng_cmd      = eng_cmd_q;
    assign o_eng_addr     = eng_addr_q;
    assign o_eng_exi_addr = eng_exi_addr_q;
    assign o_eng_dum_num  = eng_dum_q;
    assign o_eng_exi_data = eng_exi_data_q;
    assign o_eng_data_num = eng_num_q;
    assign o_eng_wr_en    = eng_wr_en_q;
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_spi_flash_seq.sv
// Bench for spi_flash_seq: behavioural SPI engine + flash status model,
// table-driven directed ops, randomized ops against a command-list model,
// and a busy-request / mid-operation reset sequence.
module tb_spi_flash_seq;
  import spi_flash_pkg::*;

  localparam logic [15:0] POLL_MAX = 16'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req;
  logic [1:0]  op;
  logic [23:0] addr;
  logic [15:0] len;
  logic        busy, done, err;
  logic [7:0]  sts;
  logic        eng_start;
  logic [7:0]  eng_cmd;
  logic [23:0] eng_addr;
  logic        eng_exi_addr;
  logic [2:0]  eng_dum;
  logic        eng_exi_data;
  logic [15:0] eng_num;
  logic        eng_wr_en;
  logic        eng_rdy;
  logic [7:0]  eng_rdata;
  logic        eng_rdata_vld;
  state_e      dbg_state;

  spi_flash_seq #(.POLL_MAX(POLL_MAX)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_op(op), .i_addr(addr), .i_len(len),
    .o_busy(busy), .o_done(done), .o_err(err), .o_sts(sts),
    .o_eng_start(eng_start), .o_eng_cmd(eng_cmd), .o_eng_addr(eng_addr),
    .o_eng_exi_addr(eng_exi_addr), .o_eng_dum_num(eng_dum), .o_eng_exi_data(eng_exi_data),
    .o_eng_data_num(eng_num), .o_eng_wr_en(eng_wr_en),
    .i_eng_rdy(eng_rdy), .i_eng_rdata(eng_rdata), .i_eng_rdata_vld(eng_rdata_vld),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic        exi_addr;
    logic [2:0]  dum;
    logic        exi_data;
    logic [15:0] num;
    logic        wr_en;
  } cmd_t;

  cmd_t got_q[$];
  cmd_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [7:0] c, input logic [23:0] a, input logic ea,
                              input logic ed, input logic [15:0] n, input logic we);
    cmd_t r;
    r.cmd = c; r.addr = a; r.exi_addr = ea; r.dum = 3'd0; r.exi_data = ed; r.num = n; r.wr_en = we;
    return r;
  endfunction

  // ---------------- engine + flash status model ----------------
  int         wip_left;
  bit         stuck;
  bit         rand_upper;
  bit         hold_busy;
  logic [7:0] last_rdata;
  int         done_cnt;
  bit         eng_active;
  bit         prev_start;
  int         drop_cnt;
  int         busy_cnt;
  logic [7:0] active_cmd;

  initial begin
    eng_rdy = 1'b1; eng_rdata_vld = 1'b0; eng_rdata = 8'h00;
    eng_active = 0; prev_start = 0; last_rdata = 8'h00; done_cnt = 0;
    hold_busy = 0; wip_left = 0; stuck = 0; rand_upper = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        eng_rdy = 1'b1; eng_rdata_vld = 1'b0; eng_active = 0; prev_start = 0; last_rdata = 8'h00;
      end else begin
        eng_rdata_vld = 1'b0;
        if (done) done_cnt++;
        if (err) check("err_with_done", {31'd0, done}, 32'd1);
        if (eng_start) begin
          check("start_protocol", {29'd0, eng_rdy, prev_start, eng_active}, 32'b100);
          got_q.push_back(mk(eng_cmd, eng_addr, eng_exi_addr, eng_exi_data, eng_num, eng_wr_en));
          got_q[got_q.size()-1].dum = eng_dum;
          eng_active = 1; active_cmd = eng_cmd;
          drop_cnt = $urandom_range(0, 1); busy_cnt = $urandom_range(1, 4);
        end
        prev_start = eng_start;
        if (eng_active) begin
          if (eng_rdy) begin
            if (drop_cnt == 0) eng_rdy = 1'b0; else drop_cnt--;
          end else if (!hold_busy) begin
            busy_cnt--;
            if (busy_cnt <= 0) begin
              if (active_cmd == CMD_RDSR) begin
                logic [7:0] b;
                b = rand_upper ? 8'($urandom_range(0, 255)) : 8'h00;
                b[0] = stuck || (wip_left > 0);
                if (!stuck && wip_left > 0) wip_left--;
                eng_rdata = b; eng_rdata_vld = 1'b1; last_rdata = b;
              end
              eng_rdy = 1'b1; eng_active = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- reference model: expected command list ----------------
  task automatic build_exp(input logic [1:0] o, input logic [23:0] a, input logic [15:0] l,
                           input int wip, input bit stk, output bit exp_err);
    int npolls;
    exp_q.delete();
    exp_err = 0;
    npolls = 0;
    case (o)
      2'b00: if (l != 0) exp_q.push_back(mk(CMD_READ, a, 1, 1, l, 0));
      2'b11: exp_q.push_back(mk(CMD_RDID, 0, 0, 1, 16'd3, 0));
      default: begin
        if (o == 2'b01 && (l == 0 || int'(a[7:0]) + int'(l) > 256)) begin
          exp_err = 1;
        end else begin
          exp_q.push_back(mk(CMD_WREN, 0, 0, 0, 0, 0));
          if (o == 2'b01) exp_q.push_back(mk(CMD_PP, a, 1, 1, l, 1));
          else            exp_q.push_back(mk(CMD_SE, a, 1, 0, 0, 0));
          if (stk || wip >= int'(POLL_MAX)) begin
            npolls = int'(POLL_MAX); exp_err = 1;
          end else begin
            npolls = wip + 1;
          end
          for (int i = 0; i < npolls; i++) exp_q.push_back(mk(CMD_RDSR, 0, 0, 1, 16'd1, 0));
        end
      end
    endcase
  endtask

  task automatic cmp_cmds(input string tag);
    check({tag, "_ncmd"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_cmd%0d", tag, i), got_q[i].cmd, exp_q[i].cmd);
      check($sformatf("%s_flags%0d", tag, i),
            {got_q[i].exi_addr, got_q[i].dum, got_q[i].exi_data, got_q[i].wr_en},
            {exp_q[i].exi_addr, exp_q[i].dum, exp_q[i].exi_data, exp_q[i].wr_en});
      if (exp_q[i].exi_addr) check($sformatf("%s_addr%0d", tag, i), got_q[i].addr, exp_q[i].addr);
      if (exp_q[i].exi_data) check($sformatf("%s_num%0d", tag, i), got_q[i].num, exp_q[i].num);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input string tag, input logic [1:0] o, input logic [23:0] a,
                        input logic [15:0] l, input int wip, input bit stk, input bit rup,
                        output int lat, output bit err_seen);
    wip_left = wip; stuck = stk; rand_upper = rup;
    got_q.delete();
    @(negedge clk);
    req = 1'b1; op = o; addr = a; len = l;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    err_seen = err;
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [23:0] addr;
    logic [15:0] len;
    int          wip;
    bit          stuck;
    bit          exp_err;
    int          exp_ncmd;
    bit          exp_sts0;
    int          max_lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int lat;
    bit err_seen;
    bit m_err;
    int done0;

    vecs[0]  = '{2'b00, 24'h001000, 16'd16,  0, 0, 0, 1, 0, 0};
    vecs[1]  = '{2'b01, 24'h000100, 16'd256, 3, 0, 0, 6, 0, 0};
    vecs[2]  = '{2'b10, 24'h010000, 16'd0,   0, 1, 1, 6, 1, 0};
    vecs[3]  = '{2'b01, 24'h0000F0, 16'd32,  0, 0, 1, 0, 1, 2};
    vecs[4]  = '{2'b00, 24'h000400, 16'd0,   0, 0, 0, 0, 1, 2};
    vecs[5]  = '{2'b11, 24'hABCDEF, 16'd9,   0, 0, 0, 1, 1, 0};
    vecs[6]  = '{2'b01, 24'h000200, 16'd0,   0, 0, 1, 0, 1, 2};
    vecs[7]  = '{2'b01, 24'h000200, 16'd257, 0, 0, 1, 0, 1, 2};
    vecs[8]  = '{2'b01, 24'h0002FF, 16'd1,   0, 0, 0, 3, 0, 0};
    vecs[9]  = '{2'b01, 24'h000380, 16'd128, 1, 0, 0, 4, 0, 0};
    vecs[10] = '{2'b10, 24'h020000, 16'd0,   3, 0, 0, 6, 0, 0};
    vecs[11] = '{2'b10, 24'h030000, 16'd0,   4, 0, 1, 6, 1, 0};
    vecs[12] = '{2'b01, 24'h000381, 16'd128, 0, 0, 1, 0, 1, 2};

    req = 1'b0; op = 2'b00; addr = 24'h0; len = 16'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    check("rst_sts", sts, 32'd0);
    check("rst_eng_ctl", {28'd0, eng_start, eng_exi_addr, eng_exi_data, eng_wr_en}, 32'd0);
    check("rst_eng_cmd", {eng_cmd, eng_dum, 5'd0, 16'd0}, 32'd0);
    check("rst_eng_addr", eng_addr, 32'd0);
    check("rst_eng_num", eng_num, 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 13; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      run_op(tag, vecs[v].op, vecs[v].addr, vecs[v].len, vecs[v].wip, vecs[v].stuck, 0, lat, err_seen);
      build_exp(vecs[v].op, vecs[v].addr, vecs[v].len, vecs[v].wip, vecs[v].stuck, m_err);
      check({tag, "_err"}, {31'd0, err_seen}, {31'd0, vecs[v].exp_err});
      check({tag, "_model_err"}, {31'd0, err_seen}, {31'd0, m_err});
      check({tag, "_ncmd_tbl"}, got_q.size(), vecs[v].exp_ncmd);
      cmp_cmds(tag);
      check({tag, "_sts"}, sts, last_rdata);
      if (vecs[v].op == 2'b01 || vecs[v].op == 2'b10)
        check({tag, "_sts0"}, {31'd0, sts[0]}, {31'd0, vecs[v].exp_sts0});
      if (vecs[v].max_lat > 0)
        check({tag, "_lat_ok"}, {31'd0, lat <= vecs[v].max_lat}, 32'd1);
    end

    // ---------------- randomized ops against the model ----------------
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  ro;
      logic [23:0] ra;
      logic [15:0] rl;
      int          rw;
      bit          rs;
      string       tag;
      tag = $sformatf("rnd%0d", n);
      ro = 2'($urandom_range(0, 3));
      ra = 24'($urandom);
      if (ro == 2'b01) rl = 16'($urandom_range(0, 258 - int'(ra[7:0])));
      else             rl = 16'($urandom_range(0, 40));
      rw = $urandom_range(0, 5);
      rs = ($urandom_range(0, 7) == 0);
      run_op(tag, ro, ra, rl, rw, rs, 1, lat, err_seen);
      build_exp(ro, ra, rl, rw, rs, m_err);
      check({tag, "_err"}, {31'd0, err_seen}, {31'd0, m_err});
      cmp_cmds(tag);
      check({tag, "_sts"}, sts, last_rdata);
    end

    // ---------------- busy request ignored, then reset mid-OP_WAIT ----------------
    got_q.delete();
    done0 = done_cnt;
    hold_busy = 1;
    @(negedge clk);
    req = 1'b1; op = 2'b00; addr = 24'h000040; len = 16'd8;
    @(negedge clk);
    req = 1'b0;
    lat = 0;
    while (got_q.size() == 0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("abort_first_start", got_q.size(), 1);
    req = 1'b1; op = 2'b01; addr = 24'h000500; len = 16'd4;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_in_op_wait", {29'd0, dbg_state}, {29'd0, ST_OP_WAIT});
    check("abort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_state_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("abort_flags", {28'd0, busy, done, err, eng_start}, 32'd0);
    check("abort_eng_fields", {eng_cmd, eng_exi_addr, eng_exi_data, eng_wr_en, eng_dum}, 32'd0);
    check("abort_eng_addr_num", {eng_addr, 8'd0} | {16'd0, eng_num}, 32'd0);
    check("abort_sts", sts, 32'd0);
    hold_busy = 0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_one_start", got_q.size(), 1);
    check("abort_no_done", done_cnt, done0);
    run_op("post_rst_rdid", 2'b11, 24'h000000, 16'd0, 0, 0, 0, lat, err_seen);
    build_exp(2'b11, 24'h000000, 16'd0, 0, 0, m_err);
    check("post_rst_rdid_err", {31'd0, err_seen}, 32'd0);
    cmp_cmds("post_rst_rdid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
